// File: rtl/pong_capture_pkg.sv
// Shared types and helpers for the pong frame-capture blocks.
// Holds the capture state encoding and frame-size arithmetic.
package pong_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam int RGB_W = 24;

  function automatic int pixels_per_frame(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/vs_edge_detect.sv
// Registers an active-low vsync and flags its falling edge (start of frame).
// The register resets high so releasing reset never fakes a frame start.
module vs_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic vs,
  output logic vs_fall
);

  logic vs_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vs_d <= 1'b1;
    else          vs_d <= vs;
  end

  assign vs_fall = vs_d & ~vs;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame-aligned capture sequencer: arms, skips whole frames, then strobes
// exactly one frame's active pixels with a linear index into a sink.
module frame_capture_ctrl
  import pong_capture_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int INDEX_WIDTH = 19,
  parameter int SKIP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [SKIP_WIDTH-1:0]  skip_frames,
  input  logic                   VGA_VS,
  input  logic                   VGA_BLANK_N,
  input  logic [7:0]             VGA_R,
  input  logic [7:0]             VGA_G,
  input  logic [7:0]             VGA_B,
  output logic                   cap_valid,
  output logic [INDEX_WIDTH-1:0] cap_index,
  output logic [RGB_W-1:0]       cap_rgb,
  output logic                   busy,
  output logic                   done,
  output logic                   err_short
);

  localparam int PIX = pixels_per_frame(WIDTH, HEIGHT);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(PIX - 1);

  cap_state_t             state, state_next;
  logic [INDEX_WIDTH-1:0] pix_cnt;
  logic [SKIP_WIDTH-1:0]  skip_cnt;
  logic                   vs_fall;
  logic                   accept_arm, start_cap, skip_dec, take_pix, short_end;

  vs_edge_detect u_vs_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .vs      (VGA_VS),
    .vs_fall (vs_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // abort wins over arm, vs_fall and pixel acceptance in the same cycle
  always_comb begin
    state_next = state;
    accept_arm = 1'b0;
    start_cap  = 1'b0;
    skip_dec   = 1'b0;
    take_pix   = 1'b0;
    short_end  = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            accept_arm = 1'b1;
            state_next = SYNC;
          end
        end
        SYNC: begin
          if (vs_fall) begin
            if (skip_cnt == '0) begin
              start_cap  = 1'b1;
              state_next = CAPTURE;
            end else begin
              skip_dec = 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (vs_fall) begin
            short_end  = 1'b1;
            state_next = DONE;
          end else if (VGA_BLANK_N) begin
            take_pix = 1'b1;
            if (pix_cnt == LAST_IDX) state_next = DONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // registered capture stage: outputs lag the sampled pixel by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_valid <= 1'b0;
      cap_index <= '0;
      cap_rgb   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_short <= 1'b0;
      pix_cnt   <= '0;
      skip_cnt  <= '0;
    end else begin
      cap_valid <= take_pix;
      if (take_pix) begin
        cap_index <= pix_cnt;
        cap_rgb   <= {VGA_R, VGA_G, VGA_B};
        pix_cnt   <= pix_cnt + INDEX_WIDTH'(1);
      end
      if (start_cap) pix_cnt <= '0;
      if (accept_arm) begin
        skip_cnt  <= skip_frames;
        err_short <= 1'b0;
      end else if (skip_dec) begin
        skip_cnt <= skip_cnt - SKIP_WIDTH'(1);
      end
      if (short_end) err_short <= 1'b1;
      busy <= (state_next == SYNC) || (state_next == CAPTURE);
      done <= (state_next == DONE) && (state != DONE);
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed-random bench for frame_capture_ctrl on a 4x2 frame with a VGA stub;
// captures are compared to the pixels the stub drove in the selected frame.
module tb_frame_capture_ctrl;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int IW  = 3;
  localparam int SW  = 8;
  localparam int PIX = W * H;

  typedef struct {
    int          frame;
    int          pix;
    logic [23:0] rgb;
    int          cyc;
  } sent_t;

  typedef struct {
    int          idx;
    logic [23:0] rgb;
    int          cyc;
  } cap_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] skip_frames = '0;
  logic          VGA_VS = 1'b1;
  logic          VGA_BLANK_N = 1'b0;
  logic [7:0]    VGA_R = '0, VGA_G = '0, VGA_B = '0;
  logic          cap_valid;
  logic [IW-1:0] cap_index;
  logic [23:0]   cap_rgb;
  logic          busy, done, err_short;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  bit    rst_pending = 1'b0;
  sent_t sent[$];
  cap_t  caps[$];

  frame_capture_ctrl #(
    .WIDTH(W), .HEIGHT(H), .INDEX_WIDTH(IW), .SKIP_WIDTH(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
    .skip_frames(skip_frames), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .cap_valid(cap_valid), .cap_index(cap_index), .cap_rgb(cap_rgb),
    .busy(busy), .done(done), .err_short(err_short)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: log every strobe with the cycle it was seen
  always @(negedge clk) begin
    if (cap_valid) caps.push_back('{int'(cap_index), cap_rgb, cyc});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst_pending) begin
      reset_n     = 1'b1;
      rst_pending = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " cap_valid"}, 64'(cap_valid), 64'd0);
    check({tag, " cap_index"}, 64'(cap_index), 64'd0);
    check({tag, " cap_rgb"},   64'(cap_rgb),   64'd0);
    check({tag, " busy"},      64'(busy),      64'd0);
    check({tag, " done"},      64'(done),      64'd0);
    check({tag, " err_short"}, 64'(err_short), 64'd0);
  endtask

  task automatic do_arm(input int skip, input string tag);
    arm = 1'b1;
    skip_frames = SW'(skip);
    step();
    arm = 1'b0;
    check({tag, " busy after arm"}, 64'(busy), 64'd1);
  endtask

  // VGA stub: vsync pulse, porch, npix active pixels with random blank gaps
  task automatic drive_frame(input int fr, input int npix, input int arm_at, input int rst_at);
    VGA_BLANK_N = 1'b0;
    VGA_VS = 1'b0;
    step();
    step();
    VGA_VS = 1'b1;
    step();
    step();
    for (int p = 0; p < npix; p++) begin
      repeat ($urandom_range(0, 2)) begin
        VGA_BLANK_N = 1'b0;
        VGA_R = 8'($urandom);
        VGA_G = 8'($urandom);
        VGA_B = 8'($urandom);
        step();
      end
      VGA_BLANK_N = 1'b1;
      VGA_R = 8'(p);
      VGA_G = 8'($urandom);
      VGA_B = 8'($urandom);
      if (p == arm_at) begin
        arm = 1'b1;
        skip_frames = SW'(5);
      end
      sent.push_back('{fr, p, {VGA_R, VGA_G, VGA_B}, cyc});
      if (p == rst_at) begin
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("t6 async reset");
        rst_pending = 1'b1;
      end
      step();
      arm = 1'b0;
    end
    VGA_BLANK_N = 1'b0;
    step();
    step();
  endtask

  // reference: the capture is the first PIX pixels of frame fr, one cycle late
  task automatic verify(input string tag, input int fr);
    sent_t exp[$];
    int    n;
    foreach (sent[i]) if (sent[i].frame == fr && exp.size() < PIX) exp.push_back(sent[i]);
    check({tag, " strobe count"}, 64'(caps.size()), 64'(exp.size()));
    n = (caps.size() < exp.size()) ? caps.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s index[%0d]", tag, i), 64'(caps[i].idx), 64'(i));
      check($sformatf("%s rgb[%0d]", tag, i), 64'(caps[i].rgb), 64'(exp[i].rgb));
      check($sformatf("%s latency[%0d]", tag, i), 64'(caps[i].cyc), 64'(exp[i].cyc + 1));
    end
    check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " err_short"}, 64'(err_short), 64'(exp.size() < PIX));
    check({tag, " busy idle"}, 64'(busy), 64'd0);
    sent.delete();
    caps.delete();
    done_cnt = 0;
  endtask

  initial begin
    #7;
    check_outputs_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step();
    caps.delete();
    done_cnt = 0;

    // 1: capture with no skip
    do_arm(0, "t1");
    drive_frame(0, PIX, -1, -1);
    verify("t1", 0);

    // 2: skip two frames, capture the third
    do_arm(2, "t2");
    drive_frame(0, PIX, -1, -1);
    drive_frame(1, PIX, -1, -1);
    check("t2 busy while skipping", 64'(busy), 64'd1);
    check("t2 no strobes while skipping", 64'(caps.size()), 64'd0);
    drive_frame(2, PIX, -1, -1);
    verify("t2", 2);

    // 3: short frame ended by the next vsync
    do_arm(0, "t3");
    drive_frame(0, 5, -1, -1);
    drive_frame(1, 0, -1, -1);
    verify("t3", 0);
    do_arm(0, "t3 rearm");
    check("t3 err_short cleared", 64'(err_short), 64'd0);

    // 4: abort together with vs_fall and arm while in SYNC
    VGA_VS = 1'b0;
    abort = 1'b1;
    arm = 1'b1;
    skip_frames = SW'(3);
    step();
    abort = 1'b0;
    arm = 1'b0;
    check("t4 busy", 64'(busy), 64'd0);
    check("t4 cap_valid", 64'(cap_valid), 64'd0);
    check("t4 done", 64'(done), 64'd0);
    drive_frame(0, PIX, -1, -1);
    drive_frame(1, PIX, -1, -1);
    check("t4 no strobes", 64'(caps.size()), 64'd0);
    check("t4 no done", 64'(done_cnt), 64'd0);
    check("t4 still idle", 64'(busy), 64'd0);
    sent.delete();
    caps.delete();
    done_cnt = 0;

    // 5: arm during capture is ignored, arm from DONE restarts
    do_arm(0, "t5");
    drive_frame(0, PIX, 3, -1);
    verify("t5", 0);
    do_arm(0, "t5 from done");
    drive_frame(0, PIX, -1, -1);
    verify("t5 restart", 0);

    // 6: asynchronous reset mid-capture
    do_arm(0, "t6");
    drive_frame(0, PIX, -1, 4);
    check("t6 strobes before reset", 64'(caps.size()), 64'd4);
    check("t6 no done", 64'(done_cnt), 64'd0);
    check("t6 idle after reset", 64'(busy), 64'd0);
    sent.delete();
    caps.delete();
    done_cnt = 0;
    drive_frame(1, PIX, -1, -1);
    check("t6 no capture unarmed", 64'(caps.size()), 64'd0);
    check("t6 no done unarmed", 64'(done_cnt), 64'd0);
    check("t6 busy unarmed", 64'(busy), 64'd0);
    sent.delete();
    caps.delete();
    done_cnt = 0;
    do_arm(1, "t6 rearm");
    drive_frame(0, PIX, -1, -1);
    drive_frame(1, PIX, -1, -1);
    verify("t6 recovery", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
